// File: rtl/mold_pkg.sv
// Shared constants and state encoding for the MoldUDP64 message assembler.
package mold_pkg;

    localparam int AXI_DATA_W = 64;
    localparam int AXI_KEEP_W = AXI_DATA_W / 8;
    localparam int ML_W       = 16;
    localparam int MSG_MAX_B  = 64;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

endpackage : mold_pkg

// File: rtl/mold_mask_cnt.sv
// Byte count of a beat: population count of the contiguous keep mask.
module mold_mask_cnt #(
    parameter int KEEP_W = 8
) (
    input  logic [KEEP_W-1:0] mask_i,
    output logic [3:0]        cnt_o
);

    // Sum the set lanes; the mask is contiguous but counting bits is cheaper than a priority search.
    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            cnt_o = cnt_o + 4'(mask_i[i]);
        end
    end

endmodule : mold_mask_cnt

// File: rtl/mold_msg_asm.sv
// Reassembles MoldUDP64 message beats into a byte-addressed buffer and
// announces each complete message with a one-cycle pulse. The buffer itself
// drives asm_data_o: it holds the finished message during the pulse cycle and
// only reloads at the end of that cycle if a new start beat arrives.
module mold_msg_asm #(
    parameter int AXI_DATA_W = 64,
    parameter int AXI_KEEP_W = AXI_DATA_W / 8,
    parameter int ML_W       = 16,
    parameter int MSG_MAX_B  = 64
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic                   mold_msg_v_i,
    input  logic                   mold_msg_start_i,
    input  logic [ML_W-1:0]        mold_msg_len_i,
    input  logic [AXI_KEEP_W-1:0]  mold_msg_mask_i,
    input  logic [AXI_DATA_W-1:0]  mold_msg_data_i,
    output logic                   asm_v_o,
    output logic [ML_W-1:0]        asm_len_o,
    output logic [7:0]             asm_type_o,
    output logic [8*MSG_MAX_B-1:0] asm_data_o,
    output logic                   asm_ovf_o,
    output logic                   asm_err_o
);

    import mold_pkg::*;

    localparam int LANE_W = (AXI_KEEP_W > 1) ? $clog2(AXI_KEEP_W) : 1;
    localparam int CNT_W  = ML_W + 1;
    localparam logic [CNT_W-1:0] MAX_B = CNT_W'(MSG_MAX_B);

    state_t                 state_q;
    logic [ML_W-1:0]        len_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [8*MSG_MAX_B-1:0] buf_q;
    logic [8*MSG_MAX_B-1:0] buf_d;
    logic                   ovf_q;
    logic                   v_q;
    logic                   err_q;

    logic [3:0]             n_bytes;
    logic [CNT_W-1:0]       base;
    logic [CNT_W-1:0]       len_eff;
    logic [CNT_W-1:0]       post;
    logic [CNT_W-1:0]       wr_end;
    logic                   ovf_beat;
    logic                   done;
    logic                   accept;

    mold_mask_cnt #(
        .KEEP_W (AXI_KEEP_W)
    ) u_mask_cnt (
        .mask_i (mold_msg_mask_i),
        .cnt_o  (n_bytes)
    );

    // Beat bookkeeping: where this beat lands, how far writes may go, and whether it finishes the message.
    always_comb begin
        accept   = mold_msg_v_i && (mold_msg_start_i || (state_q == COLLECT));
        base     = mold_msg_start_i ? '0 : cnt_q;
        len_eff  = mold_msg_start_i ? {1'b0, mold_msg_len_i} : {1'b0, len_q};
        post     = base + CNT_W'(n_bytes);
        // Writes stop at the message length; anything past the buffer end is what overflow means.
        wr_end   = (post < len_eff) ? post : len_eff;
        ovf_beat = (wr_end > MAX_B);
        done     = (post >= len_eff);
    end

    // Per-byte write decode: byte gi takes lane (gi - base) when it lies in [base, wr_end).
    genvar gi;
    generate
        for (gi = 0; gi < MSG_MAX_B; gi++) begin : g_byte
            localparam logic [CNT_W-1:0] K = CNT_W'(gi);
            logic [LANE_W-1:0] lane;
            logic              wr;

            assign lane = LANE_W'(K - base);
            assign wr   = accept && (K >= base) && (K < wr_end);
            assign buf_d[8*gi +: 8] = wr ? mold_msg_data_i[8*lane +: 8]
                                    : (accept && mold_msg_start_i) ? 8'h00
                                    : buf_q[8*gi +: 8];
        end
    endgenerate

    // IDLE/COLLECT state machine with registered pulses and message registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            ovf_q   <= 1'b0;
            v_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            v_q   <= 1'b0;
            err_q <= 1'b0;
            if (mold_msg_v_i) begin
                if (accept) begin
                    buf_q <= buf_d;
                    cnt_q <= post;
                    if (mold_msg_start_i) begin
                        len_q <= mold_msg_len_i;
                        ovf_q <= ovf_beat;
                        // A start while collecting abandons the unfinished message.
                        err_q <= (state_q == COLLECT);
                    end else begin
                        ovf_q <= ovf_q | ovf_beat;
                    end
                    if (done) begin
                        v_q     <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        state_q <= COLLECT;
                    end
                end else begin
                    // Continuation with no message open: drop it.
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign asm_v_o    = v_q;
    assign asm_err_o  = err_q;
    assign asm_len_o  = len_q;
    assign asm_ovf_o  = ovf_q;
    assign asm_data_o = buf_q;
    assign asm_type_o = buf_q[7:0];

endmodule : mold_msg_asm

// File: tb/tb_mold_msg_asm.sv
// Randomized and directed bench for mold_msg_asm against a byte-queue model.
module tb_mold_msg_asm;

    localparam int DW  = 64;
    localparam int KW  = 8;
    localparam int MLW = 16;
    localparam int MB  = 64;

    logic            clk = 1'b0;
    logic            nreset = 1'b0;
    logic            mold_msg_v_i = 1'b0;
    logic            mold_msg_start_i = 1'b0;
    logic [MLW-1:0]  mold_msg_len_i = '0;
    logic [KW-1:0]   mold_msg_mask_i = '0;
    logic [DW-1:0]   mold_msg_data_i = '0;
    logic            asm_v_o;
    logic [MLW-1:0]  asm_len_o;
    logic [7:0]      asm_type_o;
    logic [8*MB-1:0] asm_data_o;
    logic            asm_ovf_o;
    logic            asm_err_o;

    always #5 clk = ~clk;

    mold_msg_asm #(
        .AXI_DATA_W (DW),
        .AXI_KEEP_W (KW),
        .ML_W       (MLW),
        .MSG_MAX_B  (MB)
    ) dut (
        .clk              (clk),
        .nreset           (nreset),
        .mold_msg_v_i     (mold_msg_v_i),
        .mold_msg_start_i (mold_msg_start_i),
        .mold_msg_len_i   (mold_msg_len_i),
        .mold_msg_mask_i  (mold_msg_mask_i),
        .mold_msg_data_i  (mold_msg_data_i),
        .asm_v_o          (asm_v_o),
        .asm_len_o        (asm_len_o),
        .asm_type_o       (asm_type_o),
        .asm_data_o       (asm_data_o),
        .asm_ovf_o        (asm_ovf_o),
        .asm_err_o        (asm_err_o)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Model: every byte received for the open message, in order, unbounded.
    byte unsigned mq[$];
    bit           m_active = 1'b0;
    int           m_len    = 0;

    task automatic chk(input string tag, input logic [8*MB-1:0] got, input logic [8*MB-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One cycle of stimulus; outputs are checked #1 after the edge that samples it.
    task automatic beat(input bit v, input bit st, input int len, input int n, input logic [DW-1:0] data);
        bit              e_err = 1'b0;
        bit              e_v   = 1'b0;
        bit              go    = 1'b0;
        bit              e_ovf = 1'b0;
        int              e_len = 0;
        int              kept;
        logic [8*MB-1:0] e_data = '0;

        mold_msg_v_i     = v;
        mold_msg_start_i = st;
        mold_msg_len_i   = MLW'(len);
        mold_msg_mask_i  = KW'((1 << n) - 1);
        mold_msg_data_i  = data;

        if (v) begin
            if (st) begin
                e_err    = m_active;
                mq.delete();
                m_len    = len;
                m_active = 1'b1;
                go       = 1'b1;
            end else if (m_active) begin
                go = 1'b1;
            end else begin
                e_err = 1'b1;
            end
            if (go) begin
                for (int i = 0; i < n; i++) mq.push_back(data[8*i +: 8]);
                if (mq.size() >= m_len) begin
                    e_v      = 1'b1;
                    m_active = 1'b0;
                    e_len    = m_len;
                    kept     = (mq.size() < m_len) ? mq.size() : m_len;
                    e_ovf    = (kept > MB);
                    for (int k = 0; k < MB; k++)
                        if (k < kept) e_data[8*k +: 8] = mq[k];
                end
            end
        end

        @(posedge clk);
        #1;
        chk("err", asm_err_o, e_err);
        chk("v", asm_v_o, e_v);
        if (e_v) begin
            chk("len", asm_len_o, e_len);
            chk("type", asm_type_o, e_data[7:0]);
            chk("ovf", asm_ovf_o, e_ovf);
            chk("data", asm_data_o, e_data);
        end
        mold_msg_v_i = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        nreset   = 1'b0;
        m_active = 1'b0;
        mq.delete();
        #1;
        chk("rst_v", asm_v_o, 0);
        chk("rst_err", asm_err_o, 0);
        @(negedge clk);
        nreset = 1'b1;
    endtask

    function automatic logic [DW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_v", asm_v_o, 0);
        chk("reset_err", asm_err_o, 0);
        chk("reset_ovf", asm_ovf_o, 0);
        chk("reset_len", asm_len_o, 0);
        chk("reset_type", asm_type_o, 0);
        chk("reset_data", asm_data_o, 0);
        @(negedge clk);
        nreset = 1'b1;

        // Two-beat message
        beat(1, 1, 16, 8, {16{4'hA}});
        beat(1, 0, 0, 8, {16{4'hB}});

        // Partial last beat
        beat(1, 1, 10, 8, rnd64());
        beat(1, 0, 0, 2, 64'h1234);

        // Short then zero-length, back to back
        beat(1, 1, 6, 6, 64'h0000_a1a2_a3a4_a553);
        beat(1, 1, 0, 0, rnd64());

        // Overflow: 80 bytes over 10 beats
        beat(1, 1, 80, 8, rnd64());
        repeat (9) beat(1, 0, 0, 8, rnd64());

        // Continuation in IDLE, then start-in-COLLECT that completes
        beat(1, 0, 0, 8, rnd64());
        beat(1, 1, 16, 8, rnd64());
        beat(1, 1, 8, 8, rnd64());

        // Gaps between beats
        beat(1, 1, 16, 8, {16{4'hA}});
        beat(0, 0, 0, 0, rnd64());
        beat(0, 0, 0, 0, rnd64());
        beat(1, 0, 0, 8, {16{4'hB}});

        // Reset mid-message, then a clean message
        beat(1, 1, 16, 8, rnd64());
        pulse_reset();
        beat(0, 0, 0, 0, rnd64());
        beat(1, 1, 16, 8, rnd64());
        beat(1, 0, 0, 8, rnd64());

        // Random traffic
        for (int t = 0; t < 400; t++) begin
            int  r   = $urandom_range(0, 99);
            int  n   = $urandom_range(0, 8);
            int  len = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 20) : $urandom_range(0, 100);
            bit  v   = (r >= 10);
            bit  st;
            if (m_active) st = ($urandom_range(0, 99) < 10);
            else          st = ($urandom_range(0, 99) >= 5);
            beat(v, st, len, n, rnd64());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_mold_msg_asm
